// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and helpers for the APB requester arbiter.
// Holds the sequencer state encoding and the odd-parity generator.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Upper bounds for the generic parity helper; callers
    // zero-extend into PAR_MAX_W and truncate the result.
    localparam int PAR_MAX_W = 256;
    localparam int PAR_MAX_G = 32;

    // Bit k is set so that slice k plus the bit has an odd
    // number of ones; slices are width/groups bits wide.
    function automatic logic [PAR_MAX_G-1:0] odd_parity(
        input logic [PAR_MAX_W-1:0] data,
        input int                   width,
        input int                   groups
    );
        logic [PAR_MAX_G-1:0] p;
        int                   sw;
        p  = '0;
        sw = width / groups;
        for (int k = 0; k < PAR_MAX_G; k++) begin
            if (k < groups) p[k] = 1'b1;
        end
        for (int i = 0; i < PAR_MAX_W; i++) begin
            if (i < width) p[i/sw] = p[i/sw] ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB4 bus with parity check signals between master and completer.
// Ports: PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB + *CHK from master,
// PREADY/PSLVERR/PRDATA/PRDATACHK from completer.
interface apb_master_arbiter_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int PARITY_WIDTH = 4
) ();
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [STRB_WIDTH-1:0]   PSTRB;
    logic [PARITY_WIDTH-1:0] PADDRCHK;
    logic [PARITY_WIDTH-1:0] PWDATACHK;
    logic                    PSTRBCHK;
    logic                    PREADY;
    logic                    PSLVERR;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic [PARITY_WIDTH-1:0] PRDATACHK;

    modport master (
        output PSEL, PENABLE, PWRITE,
        output PADDR, PWDATA, PSTRB,
        output PADDRCHK, PWDATACHK, PSTRBCHK,
        input  PREADY, PSLVERR,
        input  PRDATA, PRDATACHK
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE,
        input  PADDR, PWDATA, PSTRB,
        input  PADDRCHK, PWDATACHK, PSTRBCHK,
        output PREADY, PSLVERR,
        output PRDATA, PRDATACHK
    );
endinterface

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin picker: first request above i_last.
// Ports: i_req (requests), i_last (last grant index) -> o_gnt, o_idx.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx
);
    always_comb begin
        logic w_found;
        int   w_j;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        // Offsets 1..NUM_REQ so the last winner is tried last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = (int'(i_last) + k) % NUM_REQ;
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IW'(w_j);
            end
        end
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB completer among NUM_REQ requesters, round-robin.
// Ports: PCLK/PRESETn, req_* in, req_ready/rsp_* out, apb master bus.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int PARITY_WIDTH = 4,
    parameter int TIMEOUT      = 16,
    parameter int CHK_RDATA    = 1
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    apb_master_arbiter_if.master          apb
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    apb_state_e r_state;
    apb_state_e w_next;

    logic [IW-1:0]      r_last;
    logic [NUM_REQ-1:0] r_gnt;
    logic [CW-1:0]      r_cnt;

    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_strb;
    logic [PARITY_WIDTH-1:0] r_addrchk;
    logic [PARITY_WIDTH-1:0] r_wdatachk;
    logic                    r_strbchk;

    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic [NUM_REQ-1:0]      w_gnt;
    logic [IW-1:0]           w_gidx;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_abort;
    logic                    w_wr;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [STRB_WIDTH-1:0]   w_strb;
    logic [PARITY_WIDTH-1:0] w_addrchk;
    logic [PARITY_WIDTH-1:0] w_wdatachk;
    logic                    w_strbchk;
    logic [PARITY_WIDTH-1:0] w_rdchk;
    logic                    w_rd_bad;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_gidx)
    );

    assign w_accept = (r_state == IDLE) && (|w_gnt);
    assign w_done   = (r_state == ACCESS) && apb.PREADY;
    assign w_abort  = (r_state == ACCESS) && !apb.PREADY
                   && (r_cnt == CW'(TIMEOUT - 1));

    // Reads drive zero data/strobe, so parity is taken on zeros.
    assign w_wr    = req_write[w_gidx];
    assign w_addr  = req_addr[w_gidx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata = w_wr
                   ? req_wdata[w_gidx*DATA_WIDTH +: DATA_WIDTH]
                   : '0;
    assign w_strb  = w_wr
                   ? req_strb[w_gidx*STRB_WIDTH +: STRB_WIDTH]
                   : '0;

    assign w_addrchk = PARITY_WIDTH'(odd_parity(
        PAR_MAX_W'(w_addr), ADDR_WIDTH, PARITY_WIDTH));
    assign w_wdatachk = PARITY_WIDTH'(odd_parity(
        PAR_MAX_W'(w_wdata), DATA_WIDTH, PARITY_WIDTH));
    assign w_strbchk = 1'(odd_parity(
        PAR_MAX_W'(w_strb), STRB_WIDTH, 1));
    assign w_rdchk = PARITY_WIDTH'(odd_parity(
        PAR_MAX_W'(apb.PRDATA), DATA_WIDTH, PARITY_WIDTH));
    assign w_rd_bad = (CHK_RDATA != 0) && !r_write
                   && (w_rdchk != apb.PRDATACHK);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (w_done || w_abort) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // req_ready is combinational, so it is also held low in reset.
    always_comb begin
        apb.PSEL    = (r_state != IDLE);
        apb.PENABLE = (r_state == ACCESS);
        req_ready   = '0;
        if (w_accept && PRESETn) req_ready = w_gnt;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_last     <= IW'(NUM_REQ - 1);
            r_gnt      <= '0;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_addrchk  <= '0;
            r_wdatachk <= '0;
            r_strbchk  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last     <= w_gidx;
                r_gnt      <= w_gnt;
                r_write    <= w_wr;
                r_addr     <= w_addr;
                r_wdata    <= w_wdata;
                r_strb     <= w_strb;
                r_addrchk  <= w_addrchk;
                r_wdatachk <= w_wdatachk;
                r_strbchk  <= w_strbchk;
            end
            if (r_state == ACCESS) r_cnt <= r_cnt + 1'b1;
            else                   r_cnt <= '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid <= r_gnt;
            r_rsp_rdata <= r_write ? '0 : apb.PRDATA;
            r_rsp_err   <= apb.PSLVERR | w_rd_bad;
        end else if (w_abort) begin
            r_rsp_valid <= r_gnt;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;
    assign apb.PWRITE    = r_write;
    assign apb.PADDR     = r_addr;
    assign apb.PWDATA    = r_wdata;
    assign apb.PSTRB     = r_strb;
    assign apb.PADDRCHK  = r_addrchk;
    assign apb.PWDATACHK = r_wdatachk;
    assign apb.PSTRBCHK  = r_strbchk;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (NUM_REQ=2, 32-bit, TIMEOUT=16).
// The bench plays the completer and both requesters.
module tb_apb_master_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_strb = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errs = 0;
    int checks = 0;

    apb_master_arbiter_if bus ();

    apb_master_arbiter dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (bus.master)
    );

    always #5 PCLK = ~PCLK;

    task automatic set_req(input int i, input bit wr,
                           input logic [31:0] a,
                           input logic [31:0] wd,
                           input logic [3:0] st);
        req_write[i]        = wr;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = wd;
        req_strb[i*4 +: 4]    = st;
    endtask

    // Runs one transfer; the completer answers after 'waits' wait states.
    task automatic xfer(input int i, input bit wr,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] st,
                        input int waits, input bit slv,
                        input logic [31:0] rd,
                        input logic [3:0] rchk,
                        output bit ok,
                        output logic [1:0] v,
                        output logic err,
                        output logic [31:0] rdat,
                        output logic [3:0] pachk,
                        output logic [3:0] pwchk,
                        output logic psb,
                        output logic [31:0] pwd,
                        output logic [3:0] pst);
        ok = 1'b0;
        @(negedge PCLK);
        set_req(i, wr, a, wd, st);
        req_valid[i] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (req_ready[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        @(negedge PCLK);
        req_valid[i] = 1'b0;
        pachk = bus.PADDRCHK;
        pwchk = bus.PWDATACHK;
        psb   = bus.PSTRBCHK;
        pwd   = bus.PWDATA;
        pst   = bus.PSTRB;
        repeat (waits) @(negedge PCLK);
        @(negedge PCLK);
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = slv;
        bus.PRDATA    = rd;
        bus.PRDATACHK = rchk;
        @(negedge PCLK);
        v    = rsp_valid;
        err  = rsp_err;
        rdat = rsp_rdata;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn    = 1'b0;
        req_valid  = 2'b11;
        bus.PREADY = 1'b1;
        repeat (2) @(negedge PCLK);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errs++;
            $display("FAIL reset_ready got=%b exp=00", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 35'd0) begin
            errs++;
            $display("FAIL reset_rsp got=%b/%b/%h exp=0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin
            errs++;
            $display("FAIL reset_ctl got=%b%b%b exp=000",
                     bus.PSEL, bus.PENABLE, bus.PWRITE);
        end
        checks++;
        if ({bus.PADDRCHK, bus.PWDATACHK, bus.PSTRBCHK,
             bus.PADDR, bus.PSTRB} !== 45'd0) begin
            errs++;
            $display("FAIL reset_bus got=%h/%h/%b/%h exp=0",
                     bus.PADDRCHK, bus.PWDATACHK,
                     bus.PSTRBCHK, bus.PADDR);
        end
        @(negedge PCLK);
        req_valid  = 2'b00;
        bus.PREADY = 1'b0;
        PRESETn    = 1'b1;
    endtask

    // Both requesters stay valid with a zero-wait completer.
    task automatic test_contention();
        logic [1:0] g [4];
        int         t [4];
        int         n;
        n = 0;
        set_req(0, 1'b1, 32'h0000_0020, 32'h1, 4'hF);
        set_req(1, 1'b1, 32'h0000_0024, 32'h2, 4'hF);
        @(negedge PCLK);
        req_valid  = 2'b11;
        bus.PREADY = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (req_ready !== 2'b00 && n < 4) begin
                g[n] = req_ready;
                t[n] = cyc;
                n++;
            end
            @(negedge PCLK);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge PCLK);
        bus.PREADY = 1'b0;
        checks++;
        if (n != 4) begin
            errs++;
            $display("FAIL rr_count got=%0d exp=4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (g[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errs++;
                    $display("FAIL rr_grant%0d got=%b exp=%b", k,
                             g[k], (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (t[k+1] - t[k] != 3) begin
                    errs++;
                    $display("FAIL rr_gap%0d got=%0d exp=3", k,
                             t[k+1] - t[k]);
                end
            end
        end
    endtask

    // Two wait states; checks the cycle-by-cycle phase sequence.
    task automatic test_single_write();
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        set_req(0, 1'b1, 32'h0000_0004, 32'hA5A5_1234, 4'hF);
        req_valid[0] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errs++;
            $display("FAIL wr_ready got=%b exp=01", req_ready);
        end
        @(negedge PCLK);
        req_valid[0] = 1'b0;
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101) begin
            errs++;
            $display("FAIL wr_setup got=%b%b%b exp=101",
                     bus.PSEL, bus.PENABLE, bus.PWRITE);
        end
        checks++;
        if (bus.PADDR !== 32'h4 || bus.PWDATA !== 32'hA5A5_1234
            || bus.PSTRB !== 4'hF) begin
            errs++;
            $display("FAIL wr_bus got=%h/%h/%h exp=4/a5a51234/f",
                     bus.PADDR, bus.PWDATA, bus.PSTRB);
        end
        checks++;
        if ({bus.PADDRCHK, bus.PWDATACHK, bus.PSTRBCHK}
            !== 9'b1110_1110_1) begin
            errs++;
            $display("FAIL wr_chk got=%h/%h/%b exp=e/e/1",
                     bus.PADDRCHK, bus.PWDATACHK, bus.PSTRBCHK);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            checks++;
            if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
                errs++;
                $display("FAIL wr_access%0d got=%b%b exp=11", k,
                         bus.PSEL, bus.PENABLE);
            end
        end
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
        @(negedge PCLK);
        bus.PREADY = 1'b0;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0
            || rsp_rdata !== 32'h0 || bus.PSEL !== 1'b0) begin
            errs++;
            $display("FAIL wr_rsp got=%b/%b/%h/%b exp=01/0/0/0",
                     rsp_valid, rsp_err, rsp_rdata, bus.PSEL);
        end
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 2'b00) begin
            errs++;
            $display("FAIL wr_rsp_pulse got=%b exp=00", rsp_valid);
        end
    endtask

    task automatic test_read();
        bit          ok;
        logic [1:0]  v;
        logic        e, psb;
        logic [31:0] rd, pwd;
        logic [3:0]  pa, pw, pst;
        xfer(1, 1'b0, 32'h8, 32'hDEAD_BEEF, 4'hF, 1, 1'b0,
             32'h0000_00FF, 4'hF, ok, v, e, rd, pa, pw, psb, pwd, pst);
        checks++;
        if (!ok || v !== 2'b10 || e !== 1'b0 || rd !== 32'hFF) begin
            errs++;
            $display("FAIL rd_ok got=%0d/%b/%b/%h exp=1/10/0/ff",
                     ok, v, e, rd);
        end
        checks++;
        if (pwd !== 32'h0 || pst !== 4'h0 || pa !== 4'hE
            || pw !== 4'hF || psb !== 1'b1) begin
            errs++;
            $display("FAIL rd_bus got=%h/%h/%h/%h/%b exp=0/0/e/f/1",
                     pwd, pst, pa, pw, psb);
        end
        xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0,
             32'h0000_00FF, 4'hE, ok, v, e, rd, pa, pw, psb, pwd, pst);
        checks++;
        if (!ok || v !== 2'b10 || e !== 1'b1 || rd !== 32'hFF) begin
            errs++;
            $display("FAIL rd_parity got=%0d/%b/%b/%h exp=1/10/1/ff",
                     ok, v, e, rd);
        end
    endtask

    task automatic test_slverr();
        bit          ok;
        logic [1:0]  v;
        logic        e, psb;
        logic [31:0] rd, pwd;
        logic [3:0]  pa, pw, pst;
        xfer(0, 1'b1, 32'h44, 32'h0, 4'h3, 0, 1'b1,
             32'h1234_5678, 4'h0, ok, v, e, rd, pa, pw, psb, pwd, pst);
        checks++;
        if (!ok || v !== 2'b01 || e !== 1'b1 || rd !== 32'h0) begin
            errs++;
            $display("FAIL slverr got=%0d/%b/%b/%h exp=1/01/1/0",
                     ok, v, e, rd);
        end
        checks++;
        if (pa !== 4'hF || pw !== 4'hF || psb !== 1'b1) begin
            errs++;
            $display("FAIL slverr_chk got=%h/%h/%b exp=f/f/1",
                     pa, pw, psb);
        end
    endtask

    // PREADY on the last allowed ACCESS cycle still completes cleanly.
    task automatic test_ready_at_limit();
        bit          ok;
        logic [1:0]  v;
        logic        e, psb;
        logic [31:0] rd, pwd;
        logic [3:0]  pa, pw, pst;
        xfer(1, 1'b1, 32'h10, 32'h55, 4'h1, 15, 1'b0,
             32'h0, 4'h0, ok, v, e, rd, pa, pw, psb, pwd, pst);
        checks++;
        if (!ok || v !== 2'b10 || e !== 1'b0) begin
            errs++;
            $display("FAIL ready_limit got=%0d/%b/%b exp=1/10/0",
                     ok, v, e);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        bit run;
        cnt = 0;
        run = 1'b1;
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hFF;
        @(negedge PCLK);
        set_req(0, 1'b0, 32'h8, 32'h0, 4'h0);
        req_valid[0] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errs++;
            $display("FAIL to_ready got=%b exp=01", req_ready);
        end
        @(negedge PCLK);
        req_valid[0] = 1'b0;
        for (int c = 0; c < 40 && run; c++) begin
            @(negedge PCLK);
            if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) cnt++;
            else run = 1'b0;
        end
        checks++;
        if (cnt != 16 || bus.PSEL !== 1'b0) begin
            errs++;
            $display("FAIL to_cycles got=%0d/%b exp=16/0",
                     cnt, bus.PSEL);
        end
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1
            || rsp_rdata !== 32'h0) begin
            errs++;
            $display("FAIL to_rsp got=%b/%b/%h exp=01/1/0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        bus.PRDATA = 32'h0;
    endtask

    task automatic test_reset_mid();
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        set_req(1, 1'b1, 32'hC, 32'hFFFF_0000, 4'hC);
        req_valid[1] = 1'b1;
        @(negedge PCLK);
        req_valid[1] = 1'b0;
        @(negedge PCLK);
        checks++;
        if (bus.PENABLE !== 1'b1) begin
            errs++;
            $display("FAIL mid_access got=%b exp=1", bus.PENABLE);
        end
        PRESETn   = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++;
        if ({bus.PSEL, bus.PENABLE, req_ready, rsp_valid}
            !== 6'd0 || bus.PADDR !== 32'h0
            || bus.PWDATACHK !== 4'h0) begin
            errs++;
            $display("FAIL mid_reset got=%b%b/%b/%b/%h exp=0",
                     bus.PSEL, bus.PENABLE, req_ready,
                     rsp_valid, bus.PADDR);
        end
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 2'b00) begin
            errs++;
            $display("FAIL mid_no_rsp got=%b exp=00", rsp_valid);
        end
        PRESETn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errs++;
            $display("FAIL mid_regrant got=%b exp=01", req_ready);
        end
        @(negedge PCLK);
        req_valid  = 2'b00;
        bus.PREADY = 1'b1;
        repeat (4) @(negedge PCLK);
        bus.PREADY = 1'b0;
    endtask

    initial begin
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = '0;
        bus.PRDATACHK = '0;
        test_reset();
        test_contention();
        test_single_write();
        test_read();
        test_slverr();
        test_ready_at_limit();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
